// File: rtl/audio_i2s_rx.sv
// I2S receiver for a codec-mastered ADC stream: one left+right frame per valid/ready transfer.
// Define AUDIO_RX_OVERFLOW_EN to build the sticky dropped-frame flag; otherwise overflow is tied 0.
`timescale 1ns/1ps
module audio_i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_done,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [2:0]        state_dbg
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    typedef enum logic [2:0] {IDLE, ALIGN, SKIP, SHIFT, WAIT_LR} state_t;

    state_t                 state;
    logic                   chan;
    logic [CNT_W-1:0]       bitcnt;
    logic [DATA_W-1:0]      shreg;
    logic [DATA_W-1:0]      left_w;
    logic [DATA_W-1:0]      right_w;
    logic                   frame_done;
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_hist;
    logic                   lrck_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_hist <= 1'b0;
            lrck_hist <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
            bclk_hist <= bclk_sync[SYNC_STAGES-1];
            lrck_hist <= lrck_sync[SYNC_STAGES-1];
        end
    end

    logic              bclk_rise;
    logic              lrck_rise;
    logic              lrck_fall;
    logic              lrck_edge;
    logic              edge_ok;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] short_word;

    assign bclk_rise  = bclk_sync[SYNC_STAGES-1] & ~bclk_hist;
    assign lrck_rise  = lrck_sync[SYNC_STAGES-1] & ~lrck_hist;
    assign lrck_fall  = ~lrck_sync[SYNC_STAGES-1] & lrck_hist;
    assign lrck_edge  = lrck_sync[SYNC_STAGES-1] ^ lrck_hist;
    // Rising LRCK closes a left word, falling closes a right word; anything else is out of order.
    assign edge_ok    = lrck_rise ? (chan == CH_L) : (chan == CH_R);
    assign shifted    = {shreg[DATA_W-2:0], dat_sync[SYNC_STAGES-1]};
    assign short_word = shreg << (CNT_W'(DATA_W) - bitcnt);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            chan       <= CH_L;
            bitcnt     <= '0;
            shreg      <= '0;
            left_w     <= '0;
            right_w    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!init_done) begin
                state  <= IDLE;
                bitcnt <= '0;
                shreg  <= '0;
            end else begin
                case (state)
                    IDLE: state <= ALIGN;
                    ALIGN: begin
                        if (lrck_fall) begin
                            state  <= SKIP;
                            chan   <= CH_L;
                            bitcnt <= '0;
                            shreg  <= '0;
                        end
                    end
                    SKIP, SHIFT, WAIT_LR: begin
                        if (lrck_edge) begin
                            bitcnt <= '0;
                            shreg  <= '0;
                            if (edge_ok) begin
                                // A word cut short keeps its received bits MSB-aligned.
                                if (state != WAIT_LR) begin
                                    if (chan == CH_L) left_w <= short_word;
                                    else              right_w <= short_word;
                                    frame_done <= (chan == CH_R);
                                end
                                chan  <= ~chan;
                                state <= SKIP;
                            end else begin
                                state <= ALIGN;
                            end
                        end else if (bclk_rise) begin
                            if (state == SKIP) begin
                                state  <= SHIFT;
                                bitcnt <= '0;
                            end else if (state == SHIFT) begin
                                shreg <= shifted;
                                if (bitcnt != CNT_W'(DATA_W)) bitcnt <= bitcnt + 1'b1;
                                if (bitcnt == CNT_W'(DATA_W - 1)) begin
                                    if (chan == CH_L) left_w <= shifted;
                                    else              right_w <= shifted;
                                    frame_done <= (chan == CH_R);
                                    state      <= WAIT_LR;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // valid/ready: a sample transfers on any clk where out_valid && out_ready; while out_valid
    // is high and not accepted, the outputs hold and a newly completed frame is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
        end else if (frame_done) begin
            if (!out_valid || out_ready) begin
                out_left  <= left_w;
                out_right <= right_w;
                out_valid <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AUDIO_RX_OVERFLOW_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  overflow <= 1'b0;
        else if (frame_done && out_valid && !out_ready) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_audio_i2s_rx.sv
// Bench for audio_i2s_rx: I2S frame driver, table of frames, hand sequences, expected-sample queue.
`timescale 1ns/1ps
module tb_audio_i2s_rx;
`ifdef AUDIO_RX_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        init_done;
    logic        bclk;
    logic        lrck;
    logic        adcdat;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [2:0]  state_dbg;

    audio_i2s_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init_done  (init_done),
        .AUD_BCLK   (bclk),
        .AUD_ADCLRCK(lrck),
        .AUD_ADCDAT (adcdat),
        .out_left   (out_left),
        .out_right  (out_right),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          lbits;
        int          rbits;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_cmp;
    int          n_err;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // driver tasks: one BCLK period is 80 ns, LRCK/data change on the falling BCLK edge
    task automatic send_slot(input logic lr, input logic d);
        bclk   = 1'b0;
        lrck   = lr;
        adcdat = d;
        #40;
        bclk = 1'b1;
        #40;
    endtask

    task automatic send_channel(input logic lr, input logic [15:0] w, input int nbits, input int nslots);
        logic d;
        for (int s = 0; s < nslots; s++) begin
            if (s >= 1 && s <= nbits) d = w[16-s];
            else                      d = 1'($urandom_range(0, 1));
            send_slot(lr, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lb, input int rb);
        @(negedge clk);
        send_channel(1'b0, l, lb, (lb == 16) ? 20 : lb + 1);
        send_channel(1'b1, r, rb, (rb == 16) ? 20 : rb + 1);
    endtask

    // closes any short right word, then parks the receiver back in ALIGN
    task automatic flush();
        send_channel(1'b0, 16'h0000, 16, 3);
        send_channel(1'b1, 16'h0000, 16, 3);
        @(negedge clk);
        init_done = 1'b0;
        repeat (2) @(negedge clk);
        init_done = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(negedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // scoreboard: every accepted sample must match the oldest expected frame
    always @(negedge clk) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_sample: got %h, want none", {out_left, out_right});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sample", {out_left, out_right}, mon_exp);
            end
        end
    end

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        init_done = 1'b0;
        bclk      = 1'b1;
        lrck      = 1'b1;
        adcdat    = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{16'h1234, 16'hABCD, 16, 16, 16'h1234, 16'hABCD};
        vecs[1] = '{16'hFFFF, 16'h5555, 12, 16, 16'hFFF0, 16'h5555};
        vecs[2] = '{16'h0000, 16'hFFFF, 16, 16, 16'h0000, 16'hFFFF};
        vecs[3] = '{16'h8001, 16'h7FFE, 16, 16, 16'h8001, 16'h7FFE};
        vecs[4] = '{16'hC3C3, 16'hBEEF, 16,  8, 16'hC3C3, 16'hBE00};
        vecs[5] = '{16'h8000, 16'h0001,  1, 16, 16'h8000, 16'h0001};

        // reset held while the bus toggles, then init_done low: nothing captured
        repeat (3) @(negedge clk);
        init_done = 1'b1;
        send_frame(16'h1234, 16'hABCD, 16, 16);
        sample();
        chk("rst_valid", out_valid, 0);
        chk("rst_left", out_left, 0);
        chk("rst_right", out_right, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        init_done = 1'b0;
        send_frame(16'hABCD, 16'h1234, 16, 16);
        send_frame(16'h1111, 16'h2222, 16, 16);
        sample();
        chk("noinit_valid", out_valid, 0);
        chk("noinit_left", out_left, 0);
        @(negedge clk);
        init_done = 1'b1;
        repeat (2) @(negedge clk);

        // table of frames with the consumer always ready
        set_ready(1'b1);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].exp_l, vecs[i].exp_r});
            send_frame(vecs[i].l, vecs[i].r, vecs[i].lbits, vecs[i].rbits);
        end
        flush();
        drain();
        sample();
        chk("idle_valid", out_valid, 0);
        chk("ovf_before_drop", overflow, 0);

        // backpressure across two frames: second one is dropped
        set_ready(1'b0);
        exp_q.push_back(32'hA5A5_5A5A);
        send_frame(16'hA5A5, 16'h5A5A, 16, 16);
        send_frame(16'h0F0F, 16'hF0F0, 16, 16);
        flush();
        sample();
        chk("hold_valid", out_valid, 1);
        chk("hold_left", out_left, 16'hA5A5);
        chk("hold_right", out_right, 16'h5A5A);
        chk("drop_overflow", overflow, EXP_OVF);
        set_ready(1'b1);
        #2;
        chk("valid_low_after_accept", out_valid, 0);
        drain();

        // ready pulsed on the very clk frame 2 lands: accept and reload together
        set_ready(1'b0);
        exp_q.push_back(32'hB1B1_C1C1);
        send_frame(16'hB1B1, 16'hC1C1, 16, 16);
        exp_q.push_back(32'hD2D2_E2E2);
        fork
            begin
                send_channel(1'b0, 16'hD2D2, 16, 20);
                send_channel(1'b1, 16'hE2E2, 16, 20);
            end
            begin
                // last right bit rises at +2920; 2 sync flops + history + store + output load
                #2951 out_ready = 1'b1;
                #5 out_ready = 1'b0;
                #6;
                chk("swap_valid", out_valid, 1);
                chk("swap_left", out_left, 16'hD2D2);
                chk("swap_right", out_right, 16'hE2E2);
            end
        join
        flush();
        set_ready(1'b1);
        drain();
        sample();
        chk("sticky_overflow", overflow, EXP_OVF);

        // init_done drops inside a left word: partial frame must vanish
        @(negedge clk);
        send_channel(1'b0, 16'h9999, 16, 8);
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        init_done = 1'b1;
        send_channel(1'b0, 16'h9999, 16, 12);
        send_channel(1'b1, 16'h7777, 16, 20);
        exp_q.push_back(32'h1357_2468);
        send_frame(16'h1357, 16'h2468, 16, 16);
        flush();
        drain();

        // asynchronous reset with a sample pending, then resync
        set_ready(1'b0);
        send_frame(16'h4444, 16'h6666, 16, 16);
        flush();
        sample();
        chk("pending_valid", out_valid, 1);
        chk("pending_left", out_left, 16'h4444);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_left", out_left, 0);
        chk("async_rst_right", out_right, 0);
        chk("async_rst_overflow", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        set_ready(1'b1);
        exp_q.push_back(32'h7777_8888);
        send_frame(16'h7777, 16'h8888, 16, 16);
        flush();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
